watchdog_multi: RTL
===================

WATCHDOG_MULTI -- requirements
Module: watchdog_multi

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, meaning the number of independent watchdog channels (legal range 1..8).
REQ-002 The module SHALL have parameter LANE_W, default 8, meaning the width of each monitored activity lane.
REQ-003 The module SHALL have parameter CNT_W, default 8, meaning the width of the per-channel timeout counter.
REQ-004 The module SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port ena, input, 1 bit: global enable; when low, all counters hold and no transitions occur.
REQ-008 Port lane_in, input, NUM_CH*LANE_W bits: activity lanes; lane k is bits [k*LANE_W +: LANE_W].
REQ-009 Port timeout_val, input, CNT_W bits: shared timeout threshold.
REQ-010 Port window_min, input, CNT_W bits: earliest legal kick count in window mode.
REQ-011 Port window_en, input, 1 bit: enables window (early-kick) checking.
REQ-012 Port clr, input, NUM_CH bits: per-channel clear pulse.
REQ-013 Port active_o, output, NUM_CH bits: channel is in ARMED.
REQ-014 Port expired_o, output, NUM_CH bits: sticky timeout flag.
REQ-015 Port early_o, output, NUM_CH bits: sticky early-kick flag.
REQ-016 Port irq_o, output, 1 bit: registered OR of all expired_o and early_o bits.

Function
REQ-017 Each channel SHALL run a 3-state FSM: IDLE, ARMED, FAULT.
REQ-018 Kick definition: on an edge with ena=1, lane k differs from stored value ref[k].
REQ-019 IDLE: on a kick, go to ARMED, set ref := lane, and set counter := 0; otherwise hold.
REQ-020 ARMED, quiet edge (ena=1, no kick): if counter == timeout_val, go to FAULT and set expired=1; else counter := counter+1.
REQ-021 Consequently, expiry SHALL register on the (timeout_val+1)th quiet edge after arming; timeout_val=0 expires on the first quiet edge.
REQ-022 ARMED, kick with window_en=1 and counter < window_min: go to FAULT and set early=1; ref := lane.
REQ-023 ARMED, any other kick: stay ARMED, set counter := 0, and set ref := lane.
REQ-024 The counter SHALL never wrap; it stops at timeout_val by construction. window_min > timeout_val makes every kick early; this is a legal setting.
REQ-025 FAULT: hold the flags, counter, and ref; ignore lane activity until clr[k].
REQ-026 clr[k]=1 (any state) SHALL on the next edge clear the flags, set counter := 0, set ref := current lane, and go to IDLE; clr has priority over a simultaneous expiry or kick.
REQ-027 clr[k] SHALL act even when ena=0.
REQ-028 ena=0 SHALL freeze every channel (counter, ref, state) except for clr.
REQ-029 Channels SHALL be fully independent; activity on one lane SHALL never affect another.
REQ-030 irq_o SHALL lag the flag bits by exactly one cycle.
REQ-031 All outputs SHALL be registered or decoded directly from state registers; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-032 On rst=1 at an edge, every channel SHALL go to IDLE with counter=0 and ref=0.
REQ-033 On the same reset edge, active_o=0, expired_o=0, early_o=0, and irq_o=0.
REQ-034 Reset mid-count or in FAULT SHALL discard all state; rst has priority over clr and ena.

Structure
REQ-035 Package watchdog_pkg SHALL hold the channel state enum (IDLE/ARMED/FAULT) and the default parameter constants.
REQ-036 Sub-module watchdog_ch (one channel: FSM, counter, ref register, flags) SHALL be instantiated NUM_CH times via generate; the top SHALL contain only the lane slicing and the irq register.

Verification
REQ-037 Timeout: NUM_CH=4, timeout_val=10, window_en=0; lane0 0x00->0x5A at edge E, then quiet -> active_o[0]=1 from E; expired_o[0]=1 after edge E+11; irq_o=1 after edge E+12.
REQ-038 Periodic kick: timeout_val=10; lane0 changes every 8 cycles for 100 cycles -> expired_o[0] stays 0 and active_o[0] stays 1.
REQ-039 Window: window_en=1, window_min=4, timeout_val=10; arm, then kick on the 2nd quiet edge -> early_o[0]=1 and expired_o[0]=0; repeat with the kick on the 5th quiet edge -> no fault.
REQ-040 ena pause: arm, 5 quiet edges, ena=0 for 20 cycles, ena=1 -> expiry only after 6 further quiet edges (timeout_val=10).
REQ-041 Clear priority: clr[0] asserted on the same edge the counter reaches timeout_val -> expired_o[0]=0, state IDLE; lane1 armed in parallel -> unaffected.
REQ-042 Reset mid-operation: rst=1 while ch0 is in FAULT and ch2 is ARMED -> all outputs 0 next cycle; a later lane change re-arms from counter=0.

Source files
------------

// File: rtl/watchdog_pkg.sv
// rtl/watchdog_pkg.sv - shared channel state encoding and default parameters for watchdog_multi
package watchdog_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_LANE_W = 8;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FAULT = 2'd2
    } ch_state_e;

endpackage

// File: rtl/watchdog_ch.sv
// rtl/watchdog_ch.sv - one watchdog channel: kick detection, timeout counter, window check, sticky flags
module watchdog_ch
    import watchdog_pkg::*;
#(
    parameter int LANE_W = DEF_LANE_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic [CNT_W-1:0]  timeout_val_i,
    input  logic [CNT_W-1:0]  window_min_i,
    input  logic              window_en_i,
    input  logic              clr_i,
    output logic              active_o,
    output logic              expired_o,
    output logic              early_o
);

    ch_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LANE_W-1:0] ref_q, ref_d;
    logic              expired_q, expired_d;
    logic              early_q, early_d;
    logic              kick;

    assign kick = (lane_i != ref_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ref_q     <= '0;
            expired_q <= 1'b0;
            early_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_q     <= ref_d;
            expired_q <= expired_d;
            early_q   <= early_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_d     = ref_q;
        expired_d = expired_q;
        early_d   = early_q;

        if (clr_i) begin
            state_d   = IDLE;
            cnt_d     = '0;
            ref_d     = lane_i;
            expired_d = 1'b0;
            early_d   = 1'b0;
        end else if (ena_i) begin
            unique case (state_q)
                IDLE: begin
                    if (kick) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                        ref_d   = lane_i;
                    end
                end
                ARMED: begin
                    if (kick) begin
                        ref_d = lane_i;
                        if (window_en_i && (cnt_q < window_min_i)) begin
                            state_d = FAULT;
                            early_d = 1'b1;
                        end else begin
                            cnt_d = '0;
                        end
                    // >= rather than == so a threshold lowered mid-count still faults instead of wrapping
                    end else if (cnt_q >= timeout_val_i) begin
                        state_d   = FAULT;
                        expired_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                FAULT: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign active_o  = (state_q == ARMED);
    assign expired_o = expired_q;
    assign early_o   = early_q;

endmodule

// File: rtl/watchdog_multi.sv
// rtl/watchdog_multi.sv - NUM_CH independent activity watchdogs with a shared registered interrupt
module watchdog_multi
    import watchdog_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int LANE_W = DEF_LANE_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [NUM_CH*LANE_W-1:0] lane_in,
    input  logic [CNT_W-1:0]         timeout_val,
    input  logic [CNT_W-1:0]         window_min,
    input  logic                     window_en,
    input  logic [NUM_CH-1:0]        clr,
    output logic [NUM_CH-1:0]        active_o,
    output logic [NUM_CH-1:0]        expired_o,
    output logic [NUM_CH-1:0]        early_o,
    output logic                     irq_o
);

    logic irq_q, irq_d;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        watchdog_ch #(
            .LANE_W (LANE_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .ena_i         (ena),
            .lane_i        (lane_in[k*LANE_W +: LANE_W]),
            .timeout_val_i (timeout_val),
            .window_min_i  (window_min),
            .window_en_i   (window_en),
            .clr_i         (clr[k]),
            .active_o      (active_o[k]),
            .expired_o     (expired_o[k]),
            .early_o       (early_o[k])
        );
    end

    // Built from the registered flags, so irq trails them by exactly one cycle.
    assign irq_d = (|expired_o) | (|early_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule
